gty_prbs31_checker: RTL
=======================

# gty_prbs31_checker

Receive-side PRBS-31 pattern checker for one GTY lane's parallel user data. It is the counterpart to the lane's PRBS-31 transmit generator. It self-synchronises to the incoming stream, declares and drops lock, and accumulates bit-error and checked-word counts for BER measurement. It sits between the GTY RX user-data port (after gearbox/width conversion) and the test-status register block, one instance per lane, all in the RX user clock domain.

## Interface
Parameters:
- DATA_W, 32 — parallel word width; legal values 32 or 64.
- LOCK_CNT, 64 — consecutive error-free words required to declare lock (1..65535).
- UNLOCK_ERR, 8 — errored words within one 256-word window that force loss of lock (1..255).
- ERR_CNT_W, 32 — bit-error counter width.
- WORD_CNT_W, 48 — checked-word counter width.

Ports:
- clk  in  1  RX user clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data_i  in  DATA_W  received word; bit DATA_W-1 is earliest in time.
- rx_valid_i  in  1  rx_data_i is valid this cycle; there is no backpressure.
- clr_i  in  1  synchronous clear of err_cnt_o and word_cnt_o.
- locked_o  out  1  checker is in LOCKED.
- lock_lost_o  out  1  one-cycle pulse on the LOCKED→SEEK transition.
- err_cnt_o  out  ERR_CNT_W  accumulated bit errors while locked.
- word_cnt_o  out  WORD_CNT_W  words checked while locked.

## Operation
- Polynomial: x^31 + x^28 + 1, so s[n] = s[n-31] ^ s[n-28]. Non-inverted data.
- Stage 0 runs on every edge where rx_valid_i=1:
  - In SEEK: LFSR <= the latest 31 bits of rx_data_i, i.e. rx_data_i[30:0]. State becomes VERIFY and no compare is made.
  - Otherwise: err_v <= rx_data_i ^ pred, where pred is the next DATA_W bits generated from the LFSR. LFSR <= the last 31 of those bits. err_vld <= 1.
- The LFSR holds when rx_valid_i=0. err_vld <= 0 on idle cycles.
- Stage 1 runs on edges where err_vld=1:
  - VERIFY: if err_v==0, good_cnt++; on reaching LOCK_CNT, go to LOCKED and zero the window counters. If err_v!=0, go to SEEK and clear good_cnt.
  - LOCKED: err_cnt += popcount(err_v) and word_cnt += 1. win_cnt (8 bits) increments and wraps at 256. If err_v!=0, bad_cnt++.
  - LOCKED, unlock: when bad_cnt reaches UNLOCK_ERR, go to SEEK and pulse lock_lost_o. Unlock takes priority over window wrap.
  - LOCKED, window wrap: bad_cnt <= 0 on the edge where win_cnt wraps 255→0. The errored status of that final word still counts toward the unlock test on that edge.
  - SEEK: stage-1 results are ignored, since they are stale in-flight words.
- After a transition to SEEK, the next valid word reseeds the LFSR.
- clr_i=1: both counters are forced to 0 on that edge. Clear wins over a simultaneous increment. Lock state is unaffected.
- An all-zero seed is legal to accept. It cannot lock against live PRBS data and falls back to SEEK on the first mismatch.

## Timing
- Reset values: locked_o=0, lock_lost_o=0, err_cnt_o=0, word_cnt_o=0. Internally: state=SEEK, LFSR=0, err_vld=0, and all internal counters 0.
- rst_n low mid-stream takes effect immediately and asynchronously. Checking restarts from SEEK on the first valid word after release.
- Compare latency: a word sampled at edge E updates counters, state and outputs at edge E+1 (or later if rx_valid_i gaps delay nothing; stage 1 always follows stage 0 by exactly one edge).
- Lock latency: with seed at E0 and matching words at E1..E_LOCK_CNT, locked_o rises at edge E_LOCK_CNT+1.
- lock_lost_o is high for exactly one cycle, coincident with locked_o falling.
- All outputs are registered.

## Configuration
- GTY_PRBS_CHK_SAT_EN defined: err_cnt_o and word_cnt_o saturate at all-ones. An addition that would overflow leaves the counter at all-ones, and it remains there until clr_i or reset.
- GTY_PRBS_CHK_SAT_EN undefined: both counters wrap modulo 2^width.

## Test plan
- Reset: assert rst_n=0 during a valid stream. All outputs go to 0 asynchronously, and locked_o stays 0 until LOCK_CNT+1 valid words after release.
- Clean lock: PRBS-31 generator seeded 0x7FFFFFFF, DATA_W=32, continuous valid. locked_o rises exactly 65 edges after the seed word is sampled, and err_cnt_o=0. After 1000 further words, word_cnt_o=1000.
- Bit errors with gaps: while locked, flip bits 0 and 17 in one word and bit 5 in another, with rx_valid_i toggling 1-0-1. err_cnt_o=3, one edge after each errored word, and lock is held.
- Unlock: inject 8 single-bit errored words within 256 words. locked_o falls and lock_lost_o pulses once on the edge after the 8th errored word is sampled. Spreading 7 errors per window across three windows never unlocks.
- VERIFY failure: corrupt word 30 after the seed. The checker returns to SEEK, reseeds, and locks 65 edges after the reseed word.
- Clear/saturation: clr_i asserted on the same edge as an errored word gives err_cnt_o=0. With GTY_PRBS_CHK_SAT_EN, ERR_CNT_W=4 and 20 bit errors, err_cnt_o holds 15. Without the macro, err_cnt_o=4.

Source files
------------

// File: rtl/gty_prbs31_checker.sv
// PRBS-31 (x^31 + x^28 + 1) receive checker for one GTY lane: self-seeds, locks, and counts bit errors/words.
// Define GTY_PRBS_CHK_SAT_EN to make err_cnt_o and word_cnt_o saturate instead of wrap.
module gty_prbs31_checker #(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_ERR = 8,
    parameter int ERR_CNT_W  = 32,
    parameter int WORD_CNT_W = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  clr_i,
    output logic                  locked_o,
    output logic                  lock_lost_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o
);
    localparam int PC_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;

    state_t                  state_reg, state_next;
    logic [30:0]             lfsr_reg, lfsr_next, lfsr_adv;
    logic [DATA_W-1:0]       err_v_reg, err_v_next, pred;
    logic                    err_vld_reg, err_vld_next;
    logic [15:0]             good_cnt_reg, good_cnt_next;
    logic [7:0]              win_cnt_reg, win_cnt_next;
    logic [7:0]              bad_cnt_reg, bad_cnt_next;
    logic [8:0]              bad_inc;
    logic                    locked_reg, locked_next;
    logic                    lock_lost_reg, lock_lost_next;
    logic [ERR_CNT_W-1:0]    err_cnt_reg, err_cnt_next, err_cnt_add;
    logic [WORD_CNT_W-1:0]   word_cnt_reg, word_cnt_next, word_cnt_add;
    logic [DATA_W+30:0]      gen;
    logic [PC_W-1:0]         err_pop;

    // gen[0] is the oldest LFSR bit; gen[31+j] is the j-th predicted bit in time order.
    always_comb begin
        gen = '0;
        for (int i = 0; i < 31; i++) gen[i] = lfsr_reg[30-i];
        for (int i = 0; i < DATA_W; i++) gen[i+31] = gen[i] ^ gen[i+3];
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pred
            assign pred[DATA_W-1-gi] = gen[gi+31];
        end
        for (genvar gi = 0; gi < 31; gi++) begin : g_adv
            assign lfsr_adv[gi] = gen[DATA_W+30-gi];
        end
    endgenerate

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < DATA_W; i++) err_pop = err_pop + PC_W'(err_v_reg[i]);
    end

`ifdef GTY_PRBS_CHK_SAT_EN
    logic [ERR_CNT_W+7:0]  err_sum;
    logic [WORD_CNT_W:0]   word_sum;
    always_comb begin
        err_sum  = (ERR_CNT_W+8)'(err_cnt_reg) + (ERR_CNT_W+8)'(err_pop);
        word_sum = (WORD_CNT_W+1)'(word_cnt_reg) + (WORD_CNT_W+1)'(1);
        err_cnt_add  = (|err_sum[ERR_CNT_W+7:ERR_CNT_W]) ? '1 : err_sum[ERR_CNT_W-1:0];
        word_cnt_add = word_sum[WORD_CNT_W] ? '1 : word_sum[WORD_CNT_W-1:0];
    end
`else
    always_comb begin
        err_cnt_add  = err_cnt_reg + ERR_CNT_W'(err_pop);
        word_cnt_add = word_cnt_reg + WORD_CNT_W'(1);
    end
`endif

    assign bad_inc = {1'b0, bad_cnt_reg} + {8'd0, |err_v_reg};

    always_comb begin
        state_next     = state_reg;
        lfsr_next      = lfsr_reg;
        err_v_next     = err_v_reg;
        err_vld_next   = 1'b0;
        good_cnt_next  = good_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        bad_cnt_next   = bad_cnt_reg;
        lock_lost_next = 1'b0;
        err_cnt_next   = err_cnt_reg;
        word_cnt_next  = word_cnt_reg;

        // Stage 0: seed or compare the incoming word
        if (rx_valid_i) begin
            if (state_reg == SEEK) begin
                lfsr_next     = rx_data_i[30:0];
                state_next    = VERIFY;
                good_cnt_next = '0;
            end else begin
                lfsr_next    = lfsr_adv;
                err_v_next   = rx_data_i ^ pred;
                err_vld_next = 1'b1;
            end
        end

        // Stage 1: act on the previous word's error vector; results arriving in SEEK are stale
        if (err_vld_reg) begin
            case (state_reg)
                VERIFY: begin
                    if (err_v_reg == '0) begin
                        if (({1'b0, good_cnt_reg} + 17'd1) == 17'(LOCK_CNT)) begin
                            state_next    = LOCKED;
                            good_cnt_next = '0;
                            win_cnt_next  = '0;
                            bad_cnt_next  = '0;
                        end else begin
                            good_cnt_next = good_cnt_reg + 16'd1;
                        end
                    end else begin
                        state_next    = SEEK;
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    err_cnt_next  = err_cnt_add;
                    word_cnt_next = word_cnt_add;
                    win_cnt_next  = win_cnt_reg + 8'd1;
                    if (bad_inc == 9'(UNLOCK_ERR)) begin
                        state_next     = SEEK;
                        lock_lost_next = 1'b1;
                        bad_cnt_next   = '0;
                    end else if (win_cnt_reg == 8'hFF) begin
                        bad_cnt_next = '0;
                    end else begin
                        bad_cnt_next = bad_inc[7:0];
                    end
                end
                default: ;
            endcase
        end

        if (clr_i) begin
            err_cnt_next  = '0;
            word_cnt_next = '0;
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SEEK;
            lfsr_reg      <= '0;
            err_v_reg     <= '0;
            err_vld_reg   <= 1'b0;
            good_cnt_reg  <= '0;
            win_cnt_reg   <= '0;
            bad_cnt_reg   <= '0;
            locked_reg    <= 1'b0;
            lock_lost_reg <= 1'b0;
            err_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            lfsr_reg      <= lfsr_next;
            err_v_reg     <= err_v_next;
            err_vld_reg   <= err_vld_next;
            good_cnt_reg  <= good_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            bad_cnt_reg   <= bad_cnt_next;
            locked_reg    <= locked_next;
            lock_lost_reg <= lock_lost_next;
            err_cnt_reg   <= err_cnt_next;
            word_cnt_reg  <= word_cnt_next;
        end
    end

    assign locked_o    = locked_reg;
    assign lock_lost_o = lock_lost_reg;
    assign err_cnt_o   = err_cnt_reg;
    assign word_cnt_o  = word_cnt_reg;

endmodule
